aes_spi_master: RTL and testbench
=================================

# aes_spi_master

Host-side SPI master for the AES SPI slave core: it serializes one full command frame (plaintext/ciphertext, key-size byte, key) onto MOSI, generates SCLK and an active-low chip select, and captures the simultaneously returned MISO frame. The 128-bit AES result is extracted from the received frame and presented with a one-cycle valid strobe. It sits in the test/host FPGA fabric and connects pin-for-pin to the AES core's `cs`/`sclk`/`mosi`/`miso`.

## Interface
Parameters:
- FRAME_W, 392, bits per SPI frame, both directions.
- RESULT_MSB, 383, MSB index of the 128-bit result field inside the received frame.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request a frame transfer; sampled only when busy=0.
- tx_frame  input  FRAME_W  frame to send, MSB first; latched on accepted start.
- busy  output  1  high from accepted start until return to IDLE.
- rx_valid  output  1  one-cycle pulse: rx_frame/result updated.
- rx_frame  output  FRAME_W  full received frame.
- result  output  128  rx_frame[RESULT_MSB -: 128].
- cs_n  output  1  SPI chip select, active low.
- sclk  output  1  SPI clock, mode 0 (idle low).
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: cs_n=1, sclk=0, busy=0. start=1 -> latch tx_frame into tx shift register, clear bit counter, go SETUP.
- SETUP: cs_n=0, mosi=tx_frame[FRAME_W-1]; after CLK_DIV cycles drive sclk=1, go SHIFT.
- SHIFT: half-period counter counts 0..CLK_DIV-1; at terminal count sclk toggles.
  - High->low toggle: shift miso value (sampled at that same clk edge) into rx shift register LSB; increment bit counter; if counter < FRAME_W, shift tx register, mosi = next bit.
  - After the FRAME_W-th falling edge go HOLD; mosi holds last bit.
- HOLD: sclk=0, cs_n=0 for CLK_DIV cycles; then cs_n=1, rx_frame<=rx shift register, rx_valid=1 for one cycle, go GAP.
- GAP: cs_n=1 for CLK_DIV cycles (minimum deselect time), then IDLE, busy=0.
- start while busy=1: ignored, not queued. tx_frame changes after acceptance: no effect.
- Bit counter width: ceil(log2(FRAME_W+1)); no wrap inside a frame.

## Timing
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, rx_valid=0, rx_frame=0, result=0.
- busy and cs_n=0 assert on the clk edge after accepted start.
- First SCLK rising edge: CLK_DIV cycles after cs_n falls.
- SCLK period 2*CLK_DIV clk cycles, 50% duty; exactly FRAME_W rising edges per frame.
- rx_valid asserts 1 + CLK_DIV + 2*FRAME_W*CLK_DIV + CLK_DIV cycles after start accepted (3145 at defaults), same cycle cs_n rises.
- busy deasserts CLK_DIV cycles after rx_valid; next start accepted the cycle busy=0 is seen.
- MISO sampled at end of SCLK high phase (slave has CLK_DIV cycles of setup); MOSI changes only with SCLK falling or in SETUP.
- reset mid-frame: next edge returns to IDLE values (cs_n=1, sclk=0, busy=0), no rx_valid, rx_frame cleared.

## Configuration
- AES_SPI_MASTER_LOOPBACK_EN defined: rx shift register input taken from internal mosi instead of miso pin; rx_frame equals tx_frame at rx_valid. Used for bench/board self-test; miso ignored.
- Undefined (default): rx path from miso pin as described.

## Test plan
- Reset then idle 20 cycles -> cs_n=1, sclk=0, busy=0, rx_valid never pulses.
- start with tx_frame={128'h00112233445566778899aabbccddeeff, 8'h10, 128'h000102030405060708090a0b0c0d0e0f, 128'h0}, miso model returning 392'h0 plus 128'h69c4e0d86a7b0430d8cdb78070b4c55a at [383:256] -> exactly 392 SCLK rises, MOSI bitstream equals tx_frame MSB-first, result=69c4e0d8...c55a, rx_valid at cycle 3145.
- start held high across two frames -> second frame begins only after busy drops; ≥CLK_DIV cycles of cs_n=1 between frames.
- reset asserted at SCLK rise 200 -> next cycle cs_n=1, sclk=0, busy=0; no rx_valid; subsequent frame completes correctly.
- CLK_DIV=2, FRAME_W=392 -> SCLK period 4 cycles, rx_valid at cycle 1573.
- AES_SPI_MASTER_LOOPBACK_EN defined, miso tied 0, tx_frame alternating 0xA5 bytes -> rx_frame == tx_frame.

Source files
------------

// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI mode-0 master that sends one FRAME_W-bit command frame on MOSI and captures the MISO frame.
// Latency: rx_valid pulses 1 + 2*CLK_DIV + 2*FRAME_W*CLK_DIV cycles after start is accepted (3145 at defaults).
// Backpressure: none; start is ignored (not queued) while busy. Define AES_SPI_MASTER_LOOPBACK_EN to capture MOSI instead of MISO.
module aes_spi_master #(
   parameter int FRAME_W    = 392,
   parameter int RESULT_MSB = 383,
   parameter int CLK_DIV    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [FRAME_W-1:0] tx_frame,
   output logic               busy,
   output logic               rx_valid,
   output logic [FRAME_W-1:0] rx_frame,
   output logic [127:0]       result,
   output logic               cs_n,
   output logic               sclk,
   output logic               mosi,
   input  logic               miso
);

   localparam int BCW = $clog2(FRAME_W + 1);
   localparam logic [7:0]     CNT_LAST = 8'(CLK_DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_W);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
   logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
   logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
   logic               sclk_q, sclk_d;
   logic               rx_valid_q, rx_valid_d;

   logic               half_done;
   logic               last_bit_done;
   logic               rx_in;

   // Every non-idle phase is built from CLK_DIV-cycle windows; half_done marks the last cycle of one.
   assign half_done     = (cnt_q == CNT_LAST);
   assign last_bit_done = (bit_cnt_q == BIT_LAST);

`ifdef AES_SPI_MASTER_LOOPBACK_EN
   // Self-test: capture our own MOSI bit, so the received frame mirrors the sent one.
   assign rx_in = tx_sh_q[FRAME_W-1];
`else
   assign rx_in = miso;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: SHIFT only exits once the low half after the last falling edge has elapsed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SETUP;
         SETUP:   if (half_done) state_d = SHIFT;
         SHIFT:   if (half_done && !sclk_q && last_bit_done) state_d = HOLD;
         HOLD:    if (half_done) state_d = GAP;
         GAP:     if (half_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers: timing counter, bit counter, shift registers, SCLK and result capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_frame_q <= '0;
         sclk_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_frame_q <= rx_frame_d;
         sclk_q     <= sclk_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // Datapath next values: SCLK toggles at each window end; shifting happens on the falling toggle only.
   always_comb begin
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_frame_d = rx_frame_q;
      sclk_d     = sclk_q;
      rx_valid_d = 1'b0;

      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (half_done) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               tx_sh_d   = tx_frame;
               rx_sh_d   = '0;
               bit_cnt_d = '0;
            end
         end
         SETUP: begin
            if (half_done) sclk_d = 1'b1;
         end
         SHIFT: begin
            if (half_done) begin
               if (sclk_q) begin
                  // Falling toggle: MISO has been stable for the whole high phase.
                  sclk_d    = 1'b0;
                  rx_sh_d   = {rx_sh_q[FRAME_W-2:0], rx_in};
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  // The final bit stays on MOSI through HOLD and beyond.
                  if ((bit_cnt_q + BCW'(1)) != BIT_LAST) begin
                     tx_sh_d = {tx_sh_q[FRAME_W-2:0], 1'b0};
                  end
               end else if (!last_bit_done) begin
                  sclk_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (half_done) begin
               rx_valid_d = 1'b1;
               rx_frame_d = rx_sh_q;
            end
         end
         default: ;
      endcase
   end

   // Pin and status outputs: chip select is deasserted only while idle or in the deselect gap.
   always_comb begin
      cs_n = (state_q == IDLE) || (state_q == GAP);
      busy = (state_q != IDLE);
   end

   assign sclk     = sclk_q;
   assign mosi     = tx_sh_q[FRAME_W-1];
   assign rx_valid = rx_valid_q;
   assign rx_frame = rx_frame_q;
   assign result   = rx_frame_q[RESULT_MSB -: 128];

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: a cycle-timeline reference model checks every output each cycle,
// backed by literal expectations (3145 / 1573 cycle latency, 392 rises, known AES result).
module tb_aes_spi_master;

   localparam int F     = 392;
   localparam int RM    = 383;
   localparam int D     = 4;
   localparam int D2    = 2;
   localparam int R_OFF = 1 + D + 2 * F * D + D;
`ifdef AES_SPI_MASTER_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [F-1:0]  tx_frame = '0;
   logic          busy, rx_valid, cs_n, sclk, mosi;
   logic          miso = 1'b0;
   logic [F-1:0]  rx_frame;
   logic [127:0]  result;

   logic          start2 = 1'b0;
   logic [F-1:0]  tx2 = '0;
   logic          busy2, rx_valid2, cs_n2, sclk2, mosi2, miso2;
   logic [F-1:0]  rx_frame2;
   logic [127:0]  result2;

   // The second instance talks to itself through an external wire.
   assign miso2 = mosi2;

   aes_spi_master #(.FRAME_W(F), .RESULT_MSB(RM), .CLK_DIV(D)) u_dut (
      .clk(clk), .reset(reset), .start(start), .tx_frame(tx_frame),
      .busy(busy), .rx_valid(rx_valid), .rx_frame(rx_frame), .result(result),
      .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   aes_spi_master #(.FRAME_W(F), .RESULT_MSB(RM), .CLK_DIV(D2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .tx_frame(tx2),
      .busy(busy2), .rx_valid(rx_valid2), .rx_frame(rx_frame2), .result(result2),
      .cs_n(cs_n2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [F-1:0] act, input logic [F-1:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s @cycle %0d: got %b want %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s @cycle %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s: timed out waiting @cycle %0d", name, cyc);
   endtask

   function automatic logic [F-1:0] rand_frame();
      logic [F-1:0] v;
      v = '0;
      for (int i = 0; i < F; i += 32) v = {v[F-33:0], $urandom()};
      return v;
   endfunction

   // Index of the frame bit on the wire, rel cycles after acceptance (1 = first chip-select-low cycle).
   function automatic int bit_idx(input int rel);
      int r;
      r = rel - 1 - D;
      if (r < 0) return 0;
      if ((r + D) / (2 * D) > F - 1) return F - 1;
      return (r + D) / (2 * D);
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   logic [F-1:0] next_resp = '0;
   logic         m_act = 1'b0, m_armed = 1'b0, m_mosi_idle = 1'b0;
   int           m_c0 = 0, m_rel = 0, m_r = 0;
   logic [F-1:0] m_tx = '0, m_resp = '0, m_exp_rx = '0, m_rx = '0;
   logic         e_cs_n, e_sclk, e_busy, e_vld, e_mosi;

   always @(negedge clk) begin
      e_cs_n = 1'b1; e_sclk = 1'b0; e_busy = 1'b0; e_vld = 1'b0; e_mosi = m_mosi_idle;
      if (m_act) begin
         m_rel  = cyc - m_c0;
         e_busy = (m_rel <= R_OFF + D - 1);
         if (m_rel <= R_OFF - 1) begin
            e_cs_n = 1'b0;
            m_r    = m_rel - 1 - D;
            e_sclk = (m_r >= 0) && (m_r < 2 * F * D) && (((m_r / D) % 2) == 0);
            e_mosi = m_tx[F - 1 - bit_idx(m_rel)];
         end else begin
            e_mosi = m_tx[0];
         end
         if (m_rel == R_OFF) begin
            e_vld = 1'b1;
            m_rx  = m_exp_rx;
         end
      end
      if (m_armed) begin
         chk_bit("cyc_cs_n", cs_n, e_cs_n);
         chk_bit("cyc_sclk", sclk, e_sclk);
         chk_bit("cyc_mosi", mosi, e_mosi);
         chk_bit("cyc_busy", busy, e_busy);
         chk_bit("cyc_rx_valid", rx_valid, e_vld);
         chk("cyc_rx_frame", rx_frame, m_rx);
         chk("cyc_result", F'(result), F'(m_rx[RM -: 128]));
      end
      if (m_act && m_rel == R_OFF + D - 1) begin
         m_act       = 1'b0;
         m_mosi_idle = m_tx[0];
      end
      if (reset) begin
         m_act       = 1'b0;
         m_mosi_idle = 1'b0;
         m_rx        = '0;
         m_armed     = 1'b1;
      end else if (start && !e_busy) begin
         m_act    = 1'b1;
         m_c0     = cyc;
         m_tx     = tx_frame;
         m_resp   = next_resp;
         m_exp_rx = LB ? tx_frame : next_resp;
      end
   end

   // Slave model: present response bit k from the cycle after the (k-1)th fall up to the kth fall.
   always @(posedge clk) begin
      #1;
      if (m_act && (cyc - m_c0) >= 1 && (cyc - m_c0) <= R_OFF - 1)
         miso = m_resp[F - 1 - bit_idx(cyc - m_c0)];
      else
         miso = ($urandom_range(1, 0) == 1);
   end

   // ---------------- observation counters ----------------
   int           rises = 0, vcount = 0, vcyc = 0, hi_start = 0, last_gap = 0;
   logic [F-1:0] mosi_stream = '0;
   logic         p_sclk = 1'b0, p_cs_n = 1'b1, p_sclk2 = 1'b0;
   int           rises2 = 0, vcount2 = 0, vcyc2 = 0, rise2_cyc = 0, period2 = 0;

   always @(negedge clk) begin
      if (sclk === 1'b1 && p_sclk === 1'b0) begin
         rises       = rises + 1;
         mosi_stream = {mosi_stream[F-2:0], mosi};
      end
      if (rx_valid === 1'b1) begin
         vcount = vcount + 1;
         vcyc   = cyc;
      end
      if (cs_n === 1'b1 && p_cs_n === 1'b0) hi_start = cyc;
      if (cs_n === 1'b0 && p_cs_n === 1'b1) last_gap = cyc - hi_start;
      p_sclk = sclk;
      p_cs_n = cs_n;
      if (sclk2 === 1'b1 && p_sclk2 === 1'b0) begin
         rises2    = rises2 + 1;
         period2   = cyc - rise2_cyc;
         rise2_cyc = cyc;
      end
      if (rx_valid2 === 1'b1) begin
         vcount2 = vcount2 + 1;
         vcyc2   = cyc;
      end
      p_sclk2 = sclk2;
   end

   task automatic wait_valid(input int target, input string name);
      int n;
      n = 0;
      while (vcount < target && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      if (vcount < target) tmo(name);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy !== 1'b0) tmo(name);
   endtask

   // One frame from idle: returns the cycle distance from start acceptance to rx_valid.
   task automatic run_frame(input logic [F-1:0] tx, input logic [F-1:0] rsp, input string name, output int lat);
      int t0, v0;
      v0        = vcount;
      tx_frame  = tx;
      next_resp = rsp;
      start     = 1'b1;
      t0        = cyc;
      @(posedge clk); #1;
      start    = 1'b0;
      tx_frame = rand_frame();
      wait_valid(v0 + 1, name);
      lat = vcyc - t0;
      wait_idle(name);
   endtask

   logic [F-1:0] main_tx, main_rsp, frm, rsp;
   logic [127:0] exp_res;
   int           lat, r0, v0, n, t0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset values.
      chk_bit("reset_cs_n", cs_n, 1'b1);
      chk_bit("reset_sclk", sclk, 1'b0);
      chk_bit("reset_mosi", mosi, 1'b0);
      chk_bit("reset_busy", busy, 1'b0);
      chk_bit("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_rx_frame", rx_frame, '0);
      chk("reset_result", F'(result), '0);

      // Idle for 20 cycles: nothing happens.
      v0 = vcount;
      repeat (20) @(posedge clk);
      #1;
      chk_int("idle_no_rx_valid", vcount - v0, 0);
      chk_bit("idle_cs_n", cs_n, 1'b1);

      // Known AES vector.
      main_tx  = {128'h00112233445566778899aabbccddeeff, 8'h10, 128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      main_rsp = {8'h00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 256'h0};
      exp_res  = LB ? 128'h112233445566778899aabbccddeeff10 : 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      r0 = rises;
      run_frame(main_tx, main_rsp, "main", lat);
      chk_int("main_latency", lat, 3145);
      chk_int("main_sclk_rises", rises - r0, 392);
      chk("main_mosi_stream", mosi_stream, main_tx);
      chk("main_result", F'(result), F'(exp_res));

      // CLK_DIV=2 instance.
      tx2 = rand_frame();
      r0  = rises2;
      v0  = vcount2;
      start2 = 1'b1;
      t0     = cyc;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (vcount2 == v0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (vcount2 == v0) tmo("div2_rx_valid");
      chk_int("div2_latency", vcyc2 - t0, 1573);
      chk_int("div2_sclk_period", period2, 4);
      chk_int("div2_sclk_rises", rises2 - r0, 392);
      chk("div2_rx_frame", rx_frame2, tx2);
      chk("div2_result", F'(result2), F'(tx2[RM -: 128]));

      // start held high across two frames.
      v0    = vcount;
      start = 1'b1;
      n     = 0;
      while (vcount - v0 < 2 && n < 8000) begin
         tx_frame  = rand_frame();
         next_resp = rand_frame();
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      if (vcount - v0 < 2) tmo("held_start");
      chk_bit("held_gap_ge_clkdiv", (last_gap >= D), 1'b1);
      chk_int("held_gap_exact", last_gap, D + 1);
      wait_idle("held_start_idle");

      // Reset at SCLK rise 200, then a clean frame.
      r0        = rises;
      v0        = vcount;
      tx_frame  = rand_frame();
      next_resp = rand_frame();
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (rises - r0 < 200 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (rises - r0 < 200) tmo("rise200");
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk_bit("midrst_cs_n", cs_n, 1'b1);
      chk_bit("midrst_sclk", sclk, 1'b0);
      chk_bit("midrst_busy", busy, 1'b0);
      chk("midrst_rx_frame", rx_frame, '0);
      repeat (1700) @(posedge clk);
      #1;
      chk_int("midrst_no_rx_valid", vcount - v0, 0);
      frm = rand_frame();
      rsp = rand_frame();
      run_frame(frm, rsp, "after_reset", lat);
      chk_int("after_reset_latency", lat, 3145);
      chk("after_reset_rx_frame", rx_frame, LB ? frm : rsp);

      // Alternating 0xA5 pattern.
      frm = {49{8'hA5}};
      rsp = rand_frame();
      run_frame(frm, rsp, "a5", lat);
      chk("a5_rx_frame", rx_frame, LB ? frm : rsp);

      // Random frames with random idle gaps.
      for (int k = 0; k < 2; k++) begin
         repeat ($urandom_range(15, 0)) @(posedge clk);
         #1;
         frm = rand_frame();
         rsp = rand_frame();
         run_frame(frm, rsp, "rand", lat);
         chk_int("rand_latency", lat, 3145);
         chk("rand_rx_frame", rx_frame, LB ? frm : rsp);
      end

      repeat (5) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
